cpu_control_pipe: RTL and testbench

- Parametrised successor to the single-cycle RV32I control decoder.
- Decodes the ID-stage instruction into an rv32i_control_word and carries it through NUM_STAGES registered pipeline stages. Stage 0 is EX, stage NUM_STAGES-1 is WB, and the stages between are MEM stages.
- Adds the behaviour the combinational decoder lacks: JAL/JALR decode, stall/flush bubble insertion, load-use hazard detection and per-operand forwarding selects.

---
 rtl/cpu_control_pipe_pkg.sv | 106 ++++++++++
 rtl/cpu_control_pipe_decode.sv | 106 ++++++++++
 rtl/cpu_control_pipe.sv | 144 ++++++++++++++
 tb/tb_cpu_control_pipe.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_control_pipe_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_types: shared RV32I control-path types.
//   - rv32i_opcode, ALU/branch/funct3 encodings
//   - mux select encodings, including alumux2 j_imm (5) and memwbmux pcplus4 (4)
//   - rv32i_control_word: decoded control for one instruction
//   - ctrl_stage_entry_t: one post-ID pipeline slot {valid, cword, rs1, rs2}
//   - CTRL_MAX_STAGES: upper bound for the pipeline depth
// ---------------------------------------------------------------------------
package rv32i_types;

    localparam int unsigned CTRL_MAX_STAGES = 8;

    typedef enum logic [6:0] {
        op_lui   = 7'b0110111,
        op_auipc = 7'b0010111,
        op_jal   = 7'b1101111,
        op_jalr  = 7'b1100111,
        op_br    = 7'b1100011,
        op_load  = 7'b0000011,
        op_store = 7'b0100011,
        op_imm   = 7'b0010011,
        op_reg   = 7'b0110011,
        op_csr   = 7'b1110011
    } rv32i_opcode;

    typedef enum logic [2:0] {
        alu_add = 3'b000,
        alu_sll = 3'b001,
        alu_sra = 3'b010,
        alu_sub = 3'b011,
        alu_xor = 3'b100,
        alu_srl = 3'b101,
        alu_or  = 3'b110,
        alu_and = 3'b111
    } alu_ops;

    typedef enum logic [2:0] {
        beq  = 3'b000,
        bne  = 3'b001,
        blt  = 3'b100,
        bge  = 3'b101,
        bltu = 3'b110,
        bgeu = 3'b111
    } branch_funct3_t;

    typedef enum logic [2:0] {
        f3_add  = 3'b000,
        f3_sll  = 3'b001,
        f3_slt  = 3'b010,
        f3_sltu = 3'b011,
        f3_xor  = 3'b100,
        f3_sr   = 3'b101,
        f3_or   = 3'b110,
        f3_and  = 3'b111
    } arith_funct3_t;

    typedef enum logic {
        alumux1_rs1 = 1'b0,
        alumux1_pc  = 1'b1
    } alumux1_sel_t;

    typedef enum logic [2:0] {
        alumux2_i_imm = 3'd0,
        alumux2_u_imm = 3'd1,
        alumux2_b_imm = 3'd2,
        alumux2_s_imm = 3'd3,
        alumux2_rs2   = 3'd4,
        alumux2_j_imm = 3'd5
    } alumux2_sel_t;

    typedef enum logic {
        cmpmux_rs2   = 1'b0,
        cmpmux_i_imm = 1'b1
    } cmpmux_sel_t;

    typedef enum logic [2:0] {
        memwbmux_alu_out = 3'd0,
        memwbmux_br_en   = 3'd1,
        memwbmux_u_imm   = 3'd2,
        memwbmux_load    = 3'd3,
        memwbmux_pcplus4 = 3'd4
    } memwbmux_sel_t;

    typedef struct packed {
        rv32i_opcode    opcode;
        alu_ops         aluop;
        branch_funct3_t cmpop;
        alumux1_sel_t   alumux1_sel;
        alumux2_sel_t   alumux2_sel;
        cmpmux_sel_t    cmpmux_sel;
        memwbmux_sel_t  memwbmux_sel;
        logic           load_regfile;
        logic           mem_read;
        logic           mem_write;
        logic [2:0]     funct3;
        logic [4:0]     rd;
    } rv32i_control_word;

    typedef struct packed {
        logic              valid;
        rv32i_control_word cword;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
    } ctrl_stage_entry_t;

endpackage

// File: rtl/cpu_control_pipe_decode.sv
// ---------------------------------------------------------------------------
// cpu_control_decode: pure combinational RV32I control decoder (ID stage).
//   opcode_i/funct3_i/funct7_i : instruction fields
//   rd_i/rs1_i/rs2_i           : register specifiers
//   cword_o                    : decoded control word (load_regfile=0 when rd=0)
//   rs1_o/rs2_o                : source registers, zeroed when the format
//                                does not read them (also for unknown opcodes)
// ---------------------------------------------------------------------------
module cpu_control_decode
    import rv32i_types::*;
(
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [6:0]        funct7_i,
    input  logic [4:0]        rd_i,
    input  logic [4:0]        rs1_i,
    input  logic [4:0]        rs2_i,
    output rv32i_control_word cword_o,
    output logic [4:0]        rs1_o,
    output logic [4:0]        rs2_o
);

    logic unused_funct7;
    assign unused_funct7 = ^{funct7_i[6], funct7_i[4:0]};

    always_comb begin
        cword_o        = '0;
        cword_o.opcode = rv32i_opcode'(opcode_i);
        cword_o.funct3 = funct3_i;
        cword_o.rd     = rd_i;
        rs1_o          = rs1_i;
        rs2_o          = rs2_i;
        case (opcode_i)
            op_lui: begin
                cword_o.load_regfile = 1'b1;
                cword_o.memwbmux_sel = memwbmux_u_imm;
                rs1_o = '0;
                rs2_o = '0;
            end
            op_auipc: begin
                cword_o.alumux1_sel  = alumux1_pc;
                cword_o.alumux2_sel  = alumux2_u_imm;
                cword_o.load_regfile = 1'b1;
                rs1_o = '0;
                rs2_o = '0;
            end
            op_jal: begin
                cword_o.alumux1_sel  = alumux1_pc;
                cword_o.alumux2_sel  = alumux2_j_imm;
                cword_o.load_regfile = 1'b1;
                cword_o.memwbmux_sel = memwbmux_pcplus4;
                rs1_o = '0;
                rs2_o = '0;
            end
            op_jalr: begin
                cword_o.load_regfile = 1'b1;
                cword_o.memwbmux_sel = memwbmux_pcplus4;
                rs2_o = '0;
            end
            op_br: begin
                cword_o.alumux1_sel = alumux1_pc;
                cword_o.alumux2_sel = alumux2_b_imm;
                cword_o.cmpop       = branch_funct3_t'(funct3_i);
            end
            op_load: begin
                cword_o.mem_read     = 1'b1;
                cword_o.load_regfile = 1'b1;
                cword_o.memwbmux_sel = memwbmux_load;
                rs2_o = '0;
            end
            op_store: begin
                cword_o.alumux2_sel = alumux2_s_imm;
                cword_o.mem_write   = 1'b1;
            end
            op_imm, op_reg: begin
                cword_o.load_regfile = 1'b1;
                cword_o.aluop        = alu_ops'(funct3_i);
                if (opcode_i == op_imm) begin
                    cword_o.cmpmux_sel = cmpmux_i_imm;
                    rs2_o = '0;
                end else begin
                    cword_o.alumux2_sel = alumux2_rs2;
                end
                case (funct3_i)
                    f3_add:  if (opcode_i == op_reg && funct7_i[5]) cword_o.aluop = alu_sub;
                    f3_sr:   cword_o.aluop = funct7_i[5] ? alu_sra : alu_srl;
                    f3_slt:  begin
                        cword_o.cmpop        = blt;
                        cword_o.memwbmux_sel = memwbmux_br_en;
                    end
                    f3_sltu: begin
                        cword_o.cmpop        = bltu;
                        cword_o.memwbmux_sel = memwbmux_br_en;
                    end
                    default: ;
                endcase
            end
            default: begin
                rs1_o = '0;
                rs2_o = '0;
            end
        endcase
        if (rd_i == 5'd0) cword_o.load_regfile = 1'b0;
    end

endmodule

// File: rtl/cpu_control_pipe.sv
// ---------------------------------------------------------------------------
// cpu_control_pipe: decodes the ID instruction and carries its control word
// through NUM_STAGES registered stages (0 = EX, NUM_STAGES-1 = WB).
//   clk, rst (async, active high)
//   id_valid, id_opcode, id_funct3, id_funct7, id_rd, id_rs1, id_rs2 : ID inputs
//   stall_in : global freeze; flush : taken branch/jump resolved in EX
//   stage_cword / stage_valid : registered per-stage control
//   hazard_stall : load-use stall request to IF/ID
//   fwd_a_sel / fwd_b_sel : EX operand source (0 = regfile, k = stage k)
// Optional macro CPU_CTRL_PERF_EN adds perf_stall_cnt, perf_hazard_cnt and
// perf_flush_cnt (32-bit wrapping cycle counters).
// ---------------------------------------------------------------------------
module cpu_control_pipe
    import rv32i_types::*;
#(
    parameter int unsigned NUM_STAGES = 3,
    parameter int unsigned FWD_W      = $clog2(NUM_STAGES + 1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               id_valid,
    input  logic [6:0]                         id_opcode,
    input  logic [2:0]                         id_funct3,
    input  logic [6:0]                         id_funct7,
    input  logic [4:0]                         id_rd,
    input  logic [4:0]                         id_rs1,
    input  logic [4:0]                         id_rs2,
    input  logic                               stall_in,
    input  logic                               flush,
    output rv32i_control_word [NUM_STAGES-1:0] stage_cword,
    output logic [NUM_STAGES-1:0]              stage_valid,
    output logic                               hazard_stall,
    output logic [FWD_W-1:0]                   fwd_a_sel,
    output logic [FWD_W-1:0]                   fwd_b_sel
`ifdef CPU_CTRL_PERF_EN
    ,
    output logic [31:0]                        perf_stall_cnt,
    output logic [31:0]                        perf_hazard_cnt,
    output logic [31:0]                        perf_flush_cnt
`endif
);

    rv32i_control_word dec_cword;
    logic [4:0]        dec_rs1, dec_rs2;
    ctrl_stage_entry_t [NUM_STAGES-1:0] stage_q, stage_d;
    logic              load_use;
    logic              unused_stage_rs;

    cpu_control_decode u_decode (
        .opcode_i (id_opcode),
        .funct3_i (id_funct3),
        .funct7_i (id_funct7),
        .rd_i     (id_rd),
        .rs1_i    (id_rs1),
        .rs2_i    (id_rs2),
        .cword_o  (dec_cword),
        .rs1_o    (dec_rs1),
        .rs2_o    (dec_rs2)
    );

    // A producer in stage k is a forwarding source for the EX operand src.
    // Loads can only forward from WB.
    function automatic logic fwd_hit(input ctrl_stage_entry_t e, input logic is_wb,
                                     input logic [4:0] src);
        return e.valid && e.cword.load_regfile && (e.cword.rd != 5'd0) &&
               (e.cword.rd == src) && !(e.cword.mem_read && !is_wb);
    endfunction

    // The ID instruction reads its operands in EX one cycle later, by which
    // time a load now in stage k sits in k+1; it can only be forwarded once it
    // reaches WB, so only loads in stages 0..NUM_STAGES-3 block issue.
    always_comb begin
        load_use = 1'b0;
        for (int unsigned k = 0; k < NUM_STAGES - 2; k++) begin
            if (stage_q[k].valid && stage_q[k].cword.mem_read &&
                (stage_q[k].cword.rd != 5'd0) &&
                ((stage_q[k].cword.rd == dec_rs1) || (stage_q[k].cword.rd == dec_rs2)))
                load_use = 1'b1;
        end
        hazard_stall = id_valid && load_use && !flush;
    end

    // Scan oldest to youngest so the youngest matching stage wins.
    always_comb begin
        fwd_a_sel = '0;
        fwd_b_sel = '0;
        for (int unsigned k = NUM_STAGES - 1; k >= 1; k--) begin
            if (fwd_hit(stage_q[k], k == NUM_STAGES - 1, stage_q[0].rs1)) fwd_a_sel = FWD_W'(k);
            if (fwd_hit(stage_q[k], k == NUM_STAGES - 1, stage_q[0].rs2)) fwd_b_sel = FWD_W'(k);
        end
    end

    always_comb begin
        stage_d = stage_q;
        if (!stall_in) begin
            for (int unsigned k = 1; k < NUM_STAGES; k++) stage_d[k] = stage_q[k-1];
            if (flush || hazard_stall) begin
                stage_d[0] = '0;
            end else begin
                stage_d[0].valid = id_valid;
                stage_d[0].cword = dec_cword;
                stage_d[0].rs1   = dec_rs1;
                stage_d[0].rs2   = dec_rs2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stage_q <= '0;
        else     stage_q <= stage_d;
    end

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_out
        assign stage_valid[g] = stage_q[g].valid;
        assign stage_cword[g] = stage_q[g].cword;
    end

    always_comb begin
        unused_stage_rs = 1'b0;
        for (int unsigned k = 1; k < NUM_STAGES; k++)
            unused_stage_rs = unused_stage_rs ^ (^{stage_q[k].rs1, stage_q[k].rs2});
    end

`ifdef CPU_CTRL_PERF_EN
    logic [31:0] perf_stall_q, perf_hazard_q, perf_flush_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_q  <= '0;
            perf_hazard_q <= '0;
            perf_flush_q  <= '0;
        end else begin
            if (stall_in)           perf_stall_q  <= perf_stall_q + 32'd1;
            if (hazard_stall)       perf_hazard_q <= perf_hazard_q + 32'd1;
            if (flush && !stall_in) perf_flush_q  <= perf_flush_q + 32'd1;
        end
    end

    assign perf_stall_cnt  = perf_stall_q;
    assign perf_hazard_cnt = perf_hazard_q;
    assign perf_flush_cnt  = perf_flush_q;
`endif

endmodule

// File: tb/tb_cpu_control_pipe.sv
// Directed bench: a 3-stage and a 5-stage instance share one ID stream.
`define CHK(tag, obs, exp) chk(tag, 32'(obs), 32'(exp))

module tb_cpu_control_pipe;
  import rv32i_types::*;

  logic       clk, rst, id_valid, stall_in, flush;
  logic [6:0] id_opcode, id_funct7;
  logic [2:0] id_funct3;
  logic [4:0] id_rd, id_rs1, id_rs2;

  rv32i_control_word [2:0] cw3;
  logic [2:0]              v3;
  logic                    hz3;
  logic [1:0]              fa3, fb3;
  rv32i_control_word [4:0] cw5;
  logic [4:0]              v5;
  logic                    hz5;
  logic [2:0]              fa5, fb5;
`ifdef CPU_CTRL_PERF_EN
  logic [31:0] ps3, ph3, pf3, ps5, ph5, pf5;
`endif

  int vectors     = 0;
  int miscompares = 0;

  cpu_control_pipe #(.NUM_STAGES(3)) dut3 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .stall_in(stall_in), .flush(flush),
    .stage_cword(cw3), .stage_valid(v3), .hazard_stall(hz3),
    .fwd_a_sel(fa3), .fwd_b_sel(fb3)
`ifdef CPU_CTRL_PERF_EN
    , .perf_stall_cnt(ps3), .perf_hazard_cnt(ph3), .perf_flush_cnt(pf3)
`endif
  );

  cpu_control_pipe #(.NUM_STAGES(5)) dut5 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_funct3(id_funct3), .id_funct7(id_funct7), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .stall_in(stall_in), .flush(flush),
    .stage_cword(cw5), .stage_valid(v5), .hazard_stall(hz5),
    .fwd_a_sel(fa5), .fwd_b_sel(fb5)
`ifdef CPU_CTRL_PERF_EN
    , .perf_stall_cnt(ps5), .perf_hazard_cnt(ph5), .perf_flush_cnt(pf5)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (flush && (hz3 || hz5)) begin
      miscompares++;
      $error("FAIL mon_flush_hazard: hazard_stall asserted while flush=1");
    end
    if (rst && ((v3 !== 3'b000) || (v5 !== 5'b00000))) begin
      miscompares++;
      $error("FAIL mon_rst_valid: stage_valid nonzero during reset");
    end
    if (rst && ((fa3 !== 2'd0) || (fb3 !== 2'd0) || (fa5 !== 3'd0) || (fb5 !== 3'd0))) begin
      miscompares++;
      $error("FAIL mon_rst_fwd: forwarding select nonzero during reset");
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd,
                       input logic [4:0] rs1, input logic [4:0] rs2);
    id_valid  = v;
    id_opcode = op;
    id_funct3 = f3;
    id_funct7 = f7;
    id_rd     = rd;
    id_rs1    = rs1;
    id_rs2    = rs2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; stall_in = 1'b0; flush = 1'b0;
    drive(1'b0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    #1 rst = 1'b1;
    tick(); tick();

    `CHK("rst_valid3", v3, 3'b000);
    `CHK("rst_valid5", v5, 5'b00000);
    `CHK("rst_hazard", hz3, 1'b0);
    `CHK("rst_fwd_a", fa3, 2'd0);
    `CHK("rst_fwd_b", fb3, 2'd0);
    `CHK("rst_opcode", cw3[0].opcode, 7'd0);
    rst = 1'b0;

    drive(1'b1, op_load, 3'b010, 7'd0, 5'd5, 5'd2, 5'd0);
    #1 `CHK("lw_id_nohaz", hz3, 1'b0);
    tick();
    `CHK("lw_in_ex_valid", v3, 3'b001);
    `CHK("lw_memread", cw3[0].mem_read, 1'b1);
    `CHK("lw_wbsel", cw3[0].memwbmux_sel, 3'd3);
    drive(1'b1, op_reg, 3'b000, 7'd0, 5'd6, 5'd5, 5'd1);
    #1 `CHK("loaduse_haz", hz3, 1'b1);
    tick();
    `CHK("bubble_valid", v3, 3'b010);
    `CHK("haz_one_cycle", hz3, 1'b0);
    tick();
    `CHK("add_ex_valid", v3, 3'b101);
    `CHK("add_fwd_a_wb", fa3, 2'd2);
    `CHK("add_fwd_b", fb3, 2'd0);
    `CHK("add_ex_rd", cw3[0].rd, 5'd6);

    drive(1'b1, op_reg, 3'b000, 7'd0, 5'd7, 5'd1, 5'd2);
    tick();
    drive(1'b1, op_reg, 3'b000, 7'd0, 5'd7, 5'd3, 5'd4);
    tick();
    drive(1'b1, op_reg, 3'b000, 7'b0100000, 5'd8, 5'd7, 5'd9);
    tick();
    `CHK("youngest_fwd_a", fa3, 2'd1);
    `CHK("youngest_fwd_b", fb3, 2'd0);
    `CHK("sub_aluop", cw3[0].aluop, 3'd3);

    drive(1'b1, op_reg, 3'b000, 7'd0, 5'd3, 5'd1, 5'd2);
    tick();
    drive(1'b1, op_reg, 3'b000, 7'b0100000, 5'd4, 5'd3, 5'd3);
    tick();
    `CHK("sub_fwd_a", fa3, 2'd1);
    `CHK("sub_fwd_b", fb3, 2'd1);

    drive(1'b1, op_reg, 3'b000, 7'd0, 5'd0, 5'd1, 5'd2);
    tick();
    drive(1'b1, op_reg, 3'b000, 7'b0100000, 5'd4, 5'd0, 5'd0);
    tick();
    `CHK("x0_fwd_a", fa3, 2'd0);
    `CHK("x0_fwd_b", fb3, 2'd0);
    `CHK("x0_no_regwrite", cw3[1].load_regfile, 1'b0);

    drive(1'b1, op_jal, 3'b000, 7'd0, 5'd1, 5'd4, 5'd4);
    tick();
    `CHK("jal_rs_zeroed", fa3, 2'd0);
    `CHK("jal_alumux2", cw3[0].alumux2_sel, 3'd5);
    `CHK("jal_alumux1", cw3[0].alumux1_sel, 1'b1);
    drive(1'b1, op_reg, 3'b000, 7'd0, 5'd10, 5'd1, 5'd2);
    flush = 1'b1;
    tick();
    `CHK("flush_valid", v3, 3'b110);
    `CHK("flush_jal_s1", cw3[1].opcode, op_jal);
    `CHK("flush_jal_wbsel", cw3[1].memwbmux_sel, 3'd4);
    `CHK("flush_jal_regwr", cw3[1].load_regfile, 1'b1);

    stall_in = 1'b1;
    drive(1'b1, op_reg, 3'b000, 7'd0, 5'd11, 5'd1, 5'd2);
    for (int unsigned i = 0; i < 4; i++) begin
      tick();
      `CHK("stall_valid", v3, 3'b110);
      `CHK("stall_jal_s1", cw3[1].opcode, op_jal);
    end
    stall_in = 1'b0;
    tick();
    `CHK("late_flush_valid", v3, 3'b100);
    `CHK("late_flush_jal_s2", cw3[2].opcode, op_jal);
    flush = 1'b0;
    tick();
    `CHK("resume_valid", v3, 3'b001);
    `CHK("resume_rd", cw3[0].rd, 5'd11);
`ifdef CPU_CTRL_PERF_EN
    `CHK("perf_stall3", ps3, 32'd4);
    `CHK("perf_flush3", pf3, 32'd2);
    `CHK("perf_hazard3", ph3, 32'd1);
`endif

    drive(1'b1, op_reg, 3'b000, 7'd0, 5'd12, 5'd1, 5'd2);
    tick();
    drive(1'b1, op_reg, 3'b000, 7'b0100000, 5'd13, 5'd12, 5'd12);
    tick();
    `CHK("full_valid", v3, 3'b111);
    `CHK("full_fwd_a", fa3, 2'd1);
    #2 rst = 1'b1;
    drive(1'b0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    #1;
    `CHK("midrst_valid3", v3, 3'b000);
    `CHK("midrst_valid5", v5, 5'b00000);
    `CHK("midrst_fwd_a", fa3, 2'd0);
    `CHK("midrst_fwd_b", fb3, 2'd0);
`ifdef CPU_CTRL_PERF_EN
    `CHK("midrst_perf", ps3, 32'd0);
`endif
    tick();
    rst = 1'b0;

    drive(1'b1, op_load, 3'b010, 7'd0, 5'd7, 5'd2, 5'd0);
    tick();
    `CHK("n5_lw_valid", v5, 5'b00001);
    drive(1'b1, op_reg, 3'b000, 7'd0, 5'd8, 5'd7, 5'd3);
    #1;
    `CHK("n5_haz_c1", hz5, 1'b1);
    `CHK("n3_haz_c1", hz3, 1'b1);
    tick();
    `CHK("n5_haz_c2", hz5, 1'b1);
    `CHK("n3_haz_c2", hz3, 1'b0);
    tick();
    `CHK("n5_haz_c3", hz5, 1'b1);
    tick();
    `CHK("n5_haz_c4", hz5, 1'b0);
    tick();
    `CHK("n5_add_valid", v5, 5'b10001);
    `CHK("n5_fwd_a", fa5, 3'd4);
    `CHK("n5_fwd_b", fb5, 3'd0);
`ifdef CPU_CTRL_PERF_EN
    `CHK("n5_perf_hazard", ph5, 32'd3);
    `CHK("n3_perf_hazard", ph3, 32'd1);
`endif

    drive(1'b0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
